// File: rtl/fs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fs_pkg
// Description : Shared types and helpers for the Floyd-Steinberg error
//               diffuser: FSM state encoding, error types, quantiser levels
//               and the 7/16, 3/16, 5/16, 1/16 contribution function.
// Revision    : 1.0 - initial release
// ============================================================================
package fs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fs_state_e;

  // Width of a single stored/diffused error term.
  localparam int FS_ERR_W = 10;
  // Width of the quantisation error e = adj - q (covers -255..255).
  localparam int QE_W     = 10;

  typedef logic signed [FS_ERR_W-1:0] err_t;
  typedef logic signed [QE_W-1:0]     qerr_t;

  localparam int Q_HIGH = 255;
  localparam int Q_LOW  = 0;

  typedef struct packed {
    err_t e7;
    err_t e3;
    err_t e5;
    err_t e1;
  } fs_contrib_t;

  // Multiplies are built from shifts and adds; the arithmetic right shift
  // floors toward minus infinity, so negative errors round down.
  function automatic fs_contrib_t fs_contrib(input qerr_t e);
    logic signed [QE_W+2:0] v_e;
    logic signed [QE_W+2:0] v_m7;
    logic signed [QE_W+2:0] v_m3;
    logic signed [QE_W+2:0] v_m5;
    fs_contrib_t            v_c;
    v_e    = (QE_W+3)'(e);
    v_m7   = (v_e <<< 3) - v_e;
    v_m3   = (v_e <<< 1) + v_e;
    v_m5   = (v_e <<< 2) + v_e;
    v_c.e7 = FS_ERR_W'(v_m7 >>> 4);
    v_c.e3 = FS_ERR_W'(v_m3 >>> 4);
    v_c.e5 = FS_ERR_W'(v_m5 >>> 4);
    v_c.e1 = FS_ERR_W'(v_e  >>> 4);
    return v_c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fs_err_linebuf.sv
`default_nettype none
// ============================================================================
// Module      : fs_err_linebuf
// Description : Pair of row error buffers (current / next) selected by a
//               swap bit. The current row is read combinationally and the
//               cell is cleared in the same cycle; the next row takes up to
//               three accumulating writes at idx-1, idx and idx+1.
// Revision    : 1.0 - initial release
// Ports       : clk, rst      - clock, async active-high reset
//               swap          - exchange current and next rows
//               idx           - column being processed
//               rd_clr        - clear current[idx] after this read
//               rd_data       - current[idx]
//               wr_en_m/c/p   - enable next[idx-1] / next[idx] / next[idx+1]
//               wr_m/c/p      - values accumulated into those cells
// ============================================================================
module fs_err_linebuf #(
  parameter int IMAGEX = 64,
  parameter int ERR_W  = 10,
  parameter int X_W    = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    swap,
  input  logic [X_W-1:0]          idx,
  input  logic                    rd_clr,
  output logic signed [ERR_W-1:0] rd_data,
  input  logic                    wr_en_m,
  input  logic                    wr_en_c,
  input  logic                    wr_en_p,
  input  logic signed [ERR_W-1:0] wr_m,
  input  logic signed [ERR_W-1:0] wr_c,
  input  logic signed [ERR_W-1:0] wr_p
);

  localparam int c_sum_w = ERR_W + 2;
  localparam logic signed [c_sum_w-1:0] c_sat_hi = c_sum_w'((2 ** (ERR_W - 1)) - 1);
  localparam logic signed [c_sum_w-1:0] c_sat_lo = -c_sat_hi;

  logic signed [ERR_W-1:0] r_bank0 [IMAGEX];
  logic signed [ERR_W-1:0] r_bank1 [IMAGEX];
  logic                    r_sel;   // 0: bank0 is current, 1: bank1 is current

  logic                    w_hit [IMAGEX];
  logic signed [ERR_W-1:0] w_upd [IMAGEX];

  assign rd_data = r_sel ? r_bank1[idx] : r_bank0[idx];

  // Per-cell sum of every write aimed at it, then saturating accumulate.
  always_comb begin : p_accum
    logic signed [c_sum_w-1:0] v_add;
    logic signed [c_sum_w-1:0] v_sum;
    logic signed [ERR_W-1:0]   v_next;
    for (int i = 0; i < IMAGEX; i++) begin
      v_next   = r_sel ? r_bank0[i] : r_bank1[i];
      v_add    = '0;
      w_hit[i] = 1'b0;
      if (wr_en_m && (int'(idx) == i + 1)) begin
        v_add    = v_add + c_sum_w'(wr_m);
        w_hit[i] = 1'b1;
      end
      if (wr_en_c && (int'(idx) == i)) begin
        v_add    = v_add + c_sum_w'(wr_c);
        w_hit[i] = 1'b1;
      end
      if (wr_en_p && (int'(idx) + 1 == i)) begin
        v_add    = v_add + c_sum_w'(wr_p);
        w_hit[i] = 1'b1;
      end
      v_sum = c_sum_w'(v_next) + v_add;
      if (v_sum > c_sat_hi) begin
        w_upd[i] = c_sat_hi[ERR_W-1:0];
      end else if (v_sum < c_sat_lo) begin
        w_upd[i] = c_sat_lo[ERR_W-1:0];
      end else begin
        w_upd[i] = v_sum[ERR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 1'b0;
      for (int i = 0; i < IMAGEX; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else begin
      if (swap) begin
        r_sel <= !r_sel;
      end
      for (int i = 0; i < IMAGEX; i++) begin
        // Clear-on-read leaves each row zero by the time it becomes "next".
        if (rd_clr && (int'(idx) == i)) begin
          if (r_sel) r_bank1[i] <= '0;
          else       r_bank0[i] <= '0;
        end
        if (w_hit[i]) begin
          if (r_sel) r_bank0[i] <= w_upd[i];
          else       r_bank1[i] <= w_upd[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fs_error_diffuser.sv
`default_nettype none
// ============================================================================
// Module      : fs_error_diffuser
// Description : Floyd-Steinberg 1-bit quantiser for a raster-order grayscale
//               stream. Error is diffused 7/16 right (carry register),
//               3/16, 5/16, 1/16 into the next row (fs_err_linebuf).
// Revision    : 1.0 - initial release
// Config      : define FS_BYPASS_EN to add the 'bypass' input, sampled at
//               start; when set the frame is plain thresholded.
// Ports       : clk, rst            - clock, async active-high reset
//               start               - begin frame (IDLE only)
//               in_valid/in_ready   - input handshake, in_pixel sample
//               out_valid/out_ready - output handshake
//               out_bit, out_addr   - dithered pixel and y*IMAGEX+x
//               out_last            - final pixel of the frame
//               done                - pulse after last output accepted
//               busy                - RUN or FLUSH
// ============================================================================
module fs_error_diffuser
  import fs_pkg::*;
#(
  parameter int IMAGEX   = 64,
  parameter int IMAGEY   = 64,
  parameter int RGB_SIZE = 8,
  parameter int ERR_W    = 10,
  parameter int THRESH   = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef FS_BYPASS_EN
  input  logic                bypass,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RGB_SIZE-1:0] in_pixel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic [15:0]         out_addr,
  output logic                out_last,
  output logic                done,
  output logic                busy
);

  localparam int c_x_w    = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int c_y_w    = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam int c_asum_w = ERR_W + 2;
  localparam logic [c_x_w-1:0]             c_x_last = c_x_w'(IMAGEX - 1);
  localparam logic [c_y_w-1:0]             c_y_last = c_y_w'(IMAGEY - 1);
  localparam logic signed [c_asum_w-1:0]   c_qh_a   = c_asum_w'(Q_HIGH);
  localparam logic signed [QE_W-1:0]       c_thresh = QE_W'(THRESH);

  generate
    if (IMAGEX * IMAGEY > 65536) begin : g_addr_overflow
      $error("fs_error_diffuser: IMAGEX*IMAGEY exceeds the 16-bit out_addr range");
    end
  endgenerate

  fs_state_e               r_state;
  fs_state_e               w_state_nxt;
  logic [c_x_w-1:0]        r_x;
  logic [c_y_w-1:0]        r_y;
  logic [15:0]             r_addr;
  logic signed [ERR_W-1:0] r_carry;
  logic                    r_out_valid;
  logic                    r_out_bit;
  logic [15:0]             r_out_addr;
  logic                    r_out_last;
  logic                    r_done;

  logic                    w_run;
  logic                    w_accept;
  logic                    w_row_end;
  logic                    w_frame_end;
  logic                    w_flush_done;
  logic                    w_bypass;
  logic signed [ERR_W-1:0] w_err_rd;
  logic signed [c_asum_w-1:0] w_pix_ext;
  logic signed [c_asum_w-1:0] w_adj_raw;
  qerr_t                   w_adj;
  logic                    w_bit;
  qerr_t                   w_q;
  qerr_t                   w_e;
  fs_contrib_t             w_contrib;
  logic                    w_wr_base;

`ifdef FS_BYPASS_EN
  logic r_bypass;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bypass <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_bypass <= bypass;
    end
  end
  assign w_bypass = r_bypass;
`else
  assign w_bypass = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_accept && w_frame_end) w_state_nxt = FLUSH;
      FLUSH:   if (w_flush_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_run        = (r_state == RUN);
    busy         = (r_state == RUN) || (r_state == FLUSH);
    in_ready     = w_run && (!r_out_valid || out_ready);
    // Nothing new enters in FLUSH, so the register holds the final pixel.
    w_flush_done = (r_state == FLUSH) && r_out_valid && out_ready;
  end

  assign w_accept    = in_valid && in_ready;
  assign w_row_end   = (r_x == c_x_last);
  assign w_frame_end = w_row_end && (r_y == c_y_last);

  // ---------------- Datapath ----------------
  assign w_pix_ext = $signed({{(c_asum_w - RGB_SIZE){1'b0}}, in_pixel});
  assign w_adj_raw = w_bypass ? w_pix_ext
                              : w_pix_ext + c_asum_w'(w_err_rd) + c_asum_w'(r_carry);

  always_comb begin
    if (w_adj_raw[c_asum_w-1]) begin
      w_adj = '0;
    end else if (w_adj_raw > c_qh_a) begin
      w_adj = QE_W'(Q_HIGH);
    end else begin
      w_adj = w_adj_raw[QE_W-1:0];
    end
  end

  assign w_bit     = (w_adj >= c_thresh);
  assign w_q       = w_bit ? QE_W'(Q_HIGH) : QE_W'(Q_LOW);
  assign w_e       = w_adj - w_q;
  assign w_contrib = fs_contrib(w_e);

  // The last row has no row below it, so its next-buffer writes are dropped.
  assign w_wr_base = w_accept && !w_bypass && (r_y != c_y_last);

  fs_err_linebuf #(
    .IMAGEX (IMAGEX),
    .ERR_W  (ERR_W),
    .X_W    (c_x_w)
  ) u_linebuf (
    .clk     (clk),
    .rst     (rst),
    .swap    (w_accept && w_row_end),
    .idx     (r_x),
    .rd_clr  (w_accept),
    .rd_data (w_err_rd),
    .wr_en_m (w_wr_base && (r_x != '0)),
    .wr_en_c (w_wr_base),
    .wr_en_p (w_wr_base && !w_row_end),
    .wr_m    (ERR_W'(w_contrib.e3)),
    .wr_c    (ERR_W'(w_contrib.e5)),
    .wr_p    (ERR_W'(w_contrib.e1))
  );

  // ---------------- Position counters and carry ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= '0;
      r_carry <= '0;
    end else if (w_accept) begin
      r_carry <= (w_row_end || w_bypass) ? '0 : ERR_W'(w_contrib.e7);
      if (w_row_end) begin
        r_x <= '0;
        r_y <= w_frame_end ? '0 : r_y + c_y_w'(1);
      end else begin
        r_x <= r_x + c_x_w'(1);
      end
      r_addr <= w_frame_end ? '0 : r_addr + 16'd1;
    end
  end

  // ---------------- Output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_flush_done;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_bit   <= w_bit;
        r_out_addr  <= r_addr;
        r_out_last  <= w_frame_end;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fs_error_diffuser.sv
`default_nettype none
// ============================================================================
// Module      : tb_fs_error_diffuser
// Description : Directed self-checking bench for fs_error_diffuser. Expected
//               output bits come from a full-image floating-point-free
//               Floyd-Steinberg model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fs_error_diffuser;

  localparam int IMAGEX = 64;
  localparam int IMAGEY = 64;
  localparam int NPIX   = IMAGEX * IMAGEY;
  localparam int THRESH = 128;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        start     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [7:0]  in_pixel  = 8'd0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_bit;
  logic [15:0] out_addr;
  logic        out_last;
  logic        done;
  logic        busy;
`ifdef FS_BYPASS_EN
  logic        bypass    = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_bit [NPIX];
  int m_err   [IMAGEY+1][IMAGEX+2];

  always #5 clk = ~clk;

  fs_error_diffuser #(
    .IMAGEX   (IMAGEX),
    .IMAGEY   (IMAGEY),
    .RGB_SIZE (8),
    .ERR_W    (10),
    .THRESH   (THRESH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef FS_BYPASS_EN
    .bypass    (bypass),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .done      (done),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int mode, input int a);
    int v;
    case (mode)
      0:       v = 0;
      1:       v = 255;
      2:       v = 128;
      3:       v = a * 37 + (a / 64) * 11 + (a * a) / 8;
      default: v = a;
    endcase
    return 8'(v & 255);
  endfunction

  function automatic int floor16(input int v);
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  task automatic build_model(input int mode, input bit byp);
    int v;
    int e;
    bit b;
    for (int y = 0; y <= IMAGEY; y++)
      for (int x = 0; x < IMAGEX + 2; x++)
        m_err[y][x] = 0;
    for (int y = 0; y < IMAGEY; y++) begin
      for (int x = 0; x < IMAGEX; x++) begin
        v = int'(pix(mode, y * IMAGEX + x));
        if (!byp) v = v + m_err[y][x+1];
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        b = (v >= THRESH);
        exp_bit[y*IMAGEX+x] = b;
        e = v - (b ? 255 : 0);
        if (!byp) begin
          if (x < IMAGEX - 1) m_err[y][x+2] += floor16(7 * e);
          if (y < IMAGEY - 1) begin
            if (x > 0) m_err[y+1][x] += floor16(3 * e);
            m_err[y+1][x+1] += floor16(5 * e);
            if (x < IMAGEX - 1) m_err[y+1][x+2] += floor16(e);
          end
        end
      end
    end
  endtask

  // bp_at: output index at which out_ready drops for 10 cycles (-1 none)
  // glitch_at: loop cycle with a start pulse while busy (-1 none)
  // abort_at: number of accepted pixels after which rst is pulsed (-1 none)
  task automatic run_frame(input string name, input int mode, input bit byp,
                           input int bp_at, input int glitch_at, input int abort_at);
    int n_in;
    int n_out;
    int cyc;
    int bp_left;
    bit bp_used;
    build_model(mode, byp);
    @(negedge clk);
`ifdef FS_BYPASS_EN
    bypass = byp;
`endif
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef FS_BYPASS_EN
    bypass = 1'b0;
`endif
    chk({name, "_busy"}, busy, 1);
    n_in = 0; n_out = 0; cyc = 0; bp_left = 0; bp_used = 1'b0;
    while (n_out < NPIX && cyc < NPIX + 200 && (abort_at < 0 || n_in < abort_at)) begin
      if (!bp_used && bp_at >= 0 && n_out >= bp_at && out_valid) begin
        bp_left = 10;
        bp_used = 1'b1;
      end
      out_ready = (bp_left == 0);
      in_valid  = (n_in < NPIX);
      in_pixel  = pix(mode, n_in);
      start     = (cyc == glitch_at);
      #1;
      chk({name, "_done_early"}, done, 0);
      if (bp_left > 0) begin
        chk({name, "_stall_in_ready"}, in_ready, 0);
        chk({name, "_stall_valid"}, out_valid, 1);
        chk({name, "_stall_addr"}, out_addr, n_out);
        chk({name, "_stall_bit"}, out_bit, exp_bit[n_out]);
        bp_left--;
      end
      if (out_valid && out_ready) begin
        chk({name, "_bit"}, out_bit, exp_bit[n_out]);
        chk({name, "_addr"}, out_addr, n_out);
        chk({name, "_last"}, out_last, (n_out == NPIX - 1));
        n_out++;
      end
      if (in_valid && in_ready) n_in++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (abort_at >= 0) begin
      chk({name, "_abort_reached"}, n_in, abort_at);
      #2 rst = 1'b1;
      #1;
      chk({name, "_rst_valid"}, out_valid, 0);
      chk({name, "_rst_busy"}, busy, 0);
      chk({name, "_rst_in_ready"}, in_ready, 0);
      chk({name, "_rst_addr"}, out_addr, 0);
      chk({name, "_rst_done"}, done, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk({name, "_no_done"}, done, 0);
        chk({name, "_idle"}, busy, 0);
      end
    end else begin
      chk({name, "_count"}, n_out, NPIX);
      chk({name, "_done_pulse"}, done, 1);
      chk({name, "_drained"}, out_valid, 0);
      @(negedge clk);
      chk({name, "_done_clear"}, done, 0);
      chk({name, "_end_busy"}, busy, 0);
      chk({name, "_end_in_ready"}, in_ready, 0);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_bit", out_bit, 0);
    chk("reset_addr", out_addr, 0);
    chk("reset_last", out_last, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 0);
    in_valid = 1'b0;

    run_frame("zero",  0, 1'b0, -1,  -1,   -1);
    run_frame("ones",  1, 1'b0, -1,  -1,   -1);
    run_frame("mid",   2, 1'b0, -1,  -1,   -1);
    run_frame("bp",    3, 1'b0, 100, 500,  -1);
    run_frame("abort", 3, 1'b0, -1,  -1, 2000);
    run_frame("fresh", 3, 1'b0, -1,  -1,   -1);
`ifdef FS_BYPASS_EN
    run_frame("byp",   4, 1'b1, -1,  -1,   -1);
`else
    run_frame("ramp",  4, 1'b0, -1,  -1,   -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
